// File: rtl/imm_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module  : imm_decode_pipe
// Brief   : RV32I immediate decoder feeding an elastic valid/ready pipeline
//           with flush, illegal-opcode flag and a saturating illegal counter.
// Revision: 1.0 - initial release
// ============================================================================
module imm_decode_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        fmt,
  output logic              illegal,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_INV   = 3'd7;

  logic [31:0]       dec_imm32;
  logic [DATA_W-1:0] dec_imm;
  logic [2:0]        dec_fmt;
  logic              dec_illegal;

  // Every format is built as a 32-bit value whose bit 31 is the correct
  // extension bit, so one signed widening covers all of them.
  always_comb begin
    dec_imm32   = 32'd0;
    dec_fmt     = FMT_INV;
    dec_illegal = 1'b0;
    case (instr[6:0])
      7'b0010011: begin
        if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
          dec_fmt   = FMT_SHAMT;
          dec_imm32 = {27'd0, instr[24:20]};
        end else begin
          dec_fmt   = FMT_I;
          dec_imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_fmt   = FMT_R;
      end
      default: begin
        dec_fmt     = FMT_INV;
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_imm = DATA_W'($signed(dec_imm32));

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] illegal_q, illegal_d;
  logic [DATA_W-1:0] imm_q [STAGES];
  logic [DATA_W-1:0] imm_d [STAGES];
  logic [2:0]        fmt_q [STAGES];
  logic [2:0]        fmt_d [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic [STAGES-1:0] ready;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Stage k may load when any stage at or downstream of it is empty, or the
  // consumer is taking the tail entry.
  always_comb begin : ready_chain
    logic acc;
    acc   = out_ready;
    ready = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc      = acc | ~valid_q[k];
      ready[k] = acc;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    illegal_d = illegal_q;
    imm_d     = imm_q;
    fmt_d     = fmt_q;
    tag_d     = tag_q;
    if (ready[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        imm_d[0]     = dec_imm;
        fmt_d[0]     = dec_fmt;
        illegal_d[0] = dec_illegal;
        tag_d[0]     = in_tag;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (ready[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          imm_d[k]     = imm_q[k-1];
          fmt_d[k]     = fmt_q[k-1];
          illegal_d[k] = illegal_q[k-1];
          tag_d[k]     = tag_q[k-1];
        end
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      illegal_q <= '0;
      cnt_q     <= '0;
      for (int k = 0; k < STAGES; k++) begin
        imm_q[k] <= '0;
        fmt_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        imm_q[k] <= imm_d[k];
        fmt_q[k] <= fmt_d[k];
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign in_ready    = ready[0];
  assign out_valid   = valid_q[STAGES-1];
  assign imm         = imm_q[STAGES-1];
  assign fmt         = fmt_q[STAGES-1];
  assign illegal     = illegal_q[STAGES-1];
  assign out_tag     = tag_q[STAGES-1];
  assign illegal_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_imm_decode_pipe
// Brief   : Directed self-checking bench; four instances share one stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [4:0]  in_tag;

  // a: defaults, w: DATA_W=64, c: CNT_W=2, s: STAGES=3
  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_imm;
  logic [2:0]  a_fmt;
  logic [4:0]  a_out_tag;
  logic [15:0] a_cnt;
  logic        w_in_ready, w_out_valid, w_illegal;
  logic [63:0] w_imm;
  logic [2:0]  w_fmt;
  logic [4:0]  w_out_tag;
  logic [15:0] w_cnt;
  logic        c_in_ready, c_out_valid, c_illegal;
  logic [31:0] c_imm;
  logic [2:0]  c_fmt;
  logic [4:0]  c_out_tag;
  logic [1:0]  c_cnt;
  logic        s_in_ready, s_out_valid, s_illegal;
  logic [31:0] s_imm;
  logic [2:0]  s_fmt;
  logic [4:0]  s_out_tag;
  logic [15:0] s_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_decode_pipe u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal), .out_tag(a_out_tag), .illegal_cnt(a_cnt)
  );

  imm_decode_pipe #(.DATA_W(64)) u_w (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .instr(instr), .in_tag(in_tag), .out_valid(w_out_valid), .out_ready(out_ready),
    .imm(w_imm), .fmt(w_fmt), .illegal(w_illegal), .out_tag(w_out_tag), .illegal_cnt(w_cnt)
  );

  imm_decode_pipe #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .instr(instr), .in_tag(in_tag), .out_valid(c_out_valid), .out_ready(out_ready),
    .imm(c_imm), .fmt(c_fmt), .illegal(c_illegal), .out_tag(c_out_tag), .illegal_cnt(c_cnt)
  );

  imm_decode_pipe #(.STAGES(3)) u_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .instr(instr), .in_tag(in_tag), .out_valid(s_out_valid), .out_ready(out_ready),
    .imm(s_imm), .fmt(s_fmt), .illegal(s_illegal), .out_tag(s_out_tag), .illegal_cnt(s_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [4:0] t);
    in_valid = v;
    instr    = i;
    in_tag   = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_out_valid"}, a_out_valid, 1'b0);
    check({pfx, "_imm"},       a_imm,       32'd0);
    check({pfx, "_fmt"},       a_fmt,       3'd0);
    check({pfx, "_illegal"},   a_illegal,   1'b0);
    check({pfx, "_out_tag"},   a_out_tag,   5'd0);
    check({pfx, "_cnt"},       a_cnt,       16'd0);
    check({pfx, "_in_ready"},  a_in_ready,  1'b1);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0, 5'd0);
    #1;
    do_reset();
    check_reset_state("rst");

    // Single instructions, latency check on 2- and 3-stage instances
    drive(1'b1, 32'hFFF00093, 5'd3);
    tick();
    drive(1'b0, 32'd0, 5'd0);
    check("addi_lat_early", a_out_valid, 1'b0);
    tick();
    check("addi_valid", a_out_valid, 1'b1);
    check("addi_imm",   a_imm,       32'hFFFFFFFF);
    check("addi_fmt",   a_fmt,       3'd1);
    check("addi_tag",   a_out_tag,   5'd3);
    check("addi_imm64", w_imm,       64'hFFFFFFFFFFFFFFFF);
    check("s3_lat_early", s_out_valid, 1'b0);
    tick();
    check("addi_drained", a_out_valid, 1'b0);
    check("s3_valid",     s_out_valid, 1'b1);
    check("s3_imm",       s_imm,       32'hFFFFFFFF);
    tick();

    drive(1'b1, 32'h4030D093, 5'd4);
    tick();
    drive(1'b0, 32'd0, 5'd0);
    tick();
    check("srai_imm", a_imm, 32'h00000003);
    check("srai_fmt", a_fmt, 3'd6);
    check("srai_tag", a_out_tag, 5'd4);
    tick();
    tick();

    // Back-to-back stream, one result per cycle
    drive(1'b1, 32'hFE000EE3, 5'd7);
    tick();
    drive(1'b1, 32'h123452B7, 5'd8);
    tick();
    drive(1'b1, 32'h0010006F, 5'd9);
    check("bb0_valid", a_out_valid, 1'b1);
    check("bb0_imm",   a_imm,       32'hFFFFFFFC);
    check("bb0_fmt",   a_fmt,       3'd3);
    check("bb0_tag",   a_out_tag,   5'd7);
    tick();
    drive(1'b0, 32'd0, 5'd0);
    check("bb1_imm",   a_imm,       32'h12345000);
    check("bb1_fmt",   a_fmt,       3'd4);
    check("bb1_tag",   a_out_tag,   5'd8);
    check("bb1_imm64", w_imm,       64'h0000000012345000);
    tick();
    check("bb2_valid", a_out_valid, 1'b1);
    check("bb2_imm",   a_imm,       32'h00000800);
    check("bb2_fmt",   a_fmt,       3'd5);
    check("bb2_tag",   a_out_tag,   5'd9);
    tick();
    check("bb_empty", a_out_valid, 1'b0);
    tick();

    // Backpressure: two fill the pipe, the third waits
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 5'd1);
    tick();
    drive(1'b1, 32'h123452B7, 5'd2);
    tick();
    drive(1'b1, 32'h0010006F, 5'd3);
    #1;
    check("bp_full_in_ready", a_in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", a_out_valid, 1'b1);
      check("bp_hold_imm",   a_imm,       32'hFFFFFFFF);
      check("bp_hold_tag",   a_out_tag,   5'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", a_in_ready, 1'b1);
    tick();
    drive(1'b0, 32'd0, 5'd0);
    check("bp_out1_imm", a_imm,     32'h12345000);
    check("bp_out1_tag", a_out_tag, 5'd2);
    tick();
    check("bp_out2_imm", a_imm,     32'h00000800);
    check("bp_out2_tag", a_out_tag, 5'd3);
    tick();
    check("bp_empty", a_out_valid, 1'b0);

    // Illegal opcodes and counter saturation
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h00000000, 5'(10 + i));
      tick();
      if (i == 1) begin
        check("ill_valid", a_out_valid, 1'b1);
        check("ill_flag",  a_illegal,   1'b1);
        check("ill_fmt",   a_fmt,       3'd7);
        check("ill_imm",   a_imm,       32'd0);
      end
      if (i == 3) check("ill_cnt2", a_cnt, 16'd2);
    end
    drive(1'b0, 32'd0, 5'd0);
    tick();
    tick();
    tick();
    check("ill_cnt5",     a_cnt, 16'd5);
    check("ill_cnt_sat",  c_cnt, 2'd3);

    // Flush: output handoff in the flush cycle counts, input is discarded
    out_ready = 1'b0;
    drive(1'b1, 32'h00000000, 5'd20);
    tick();
    drive(1'b1, 32'hFFF00093, 5'd21);
    tick();
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h123452B7, 5'd22);
    tick();
    flush = 1'b0;
    check("flush_empty", a_out_valid, 1'b0);
    check("flush_cnt",   a_cnt,       16'd6);
    check("flush_in_ready", a_in_ready, 1'b1);
    drive(1'b1, 32'h0010006F, 5'd23);
    tick();
    drive(1'b0, 32'd0, 5'd0);
    tick();
    check("post_flush_valid", a_out_valid, 1'b1);
    check("post_flush_tag",   a_out_tag,   5'd23);
    check("post_flush_imm",   a_imm,       32'h00000800);
    tick();
    check("post_flush_empty", a_out_valid, 1'b0);

    // Reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 32'h00000000, 5'd30);
    tick();
    drive(1'b1, 32'hFE000EE3, 5'd31);
    tick();
    drive(1'b0, 32'd0, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check_reset_state("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
